// File: rtl/shared_mem_arbiter.sv
// Arbitrates N cores onto one single-port synchronous RAM with request/grant handshake,
// round-robin or fixed-priority selection, and tagged read-data return.
module shared_mem_arbiter #(
  parameter int unsigned N_CORES    = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_CORES-1:0]              req,
  input  logic [N_CORES-1:0]              wren,
  input  logic [N_CORES*ADDR_WIDTH-1:0]   addr,
  input  logic [N_CORES*DATA_WIDTH-1:0]   wdata,
  output logic [N_CORES-1:0]              gnt,
  output logic [N_CORES-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [ADDR_WIDTH-1:0]           mem_address,
  output logic [DATA_WIDTH-1:0]           mem_data,
  output logic                            mem_wren,
  input  logic [DATA_WIDTH-1:0]           mem_q
);

  localparam int unsigned IdxW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam bit UseRr = (ARB_MODE == 0) && (N_CORES > 1);

  logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] data_hold_q;
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [IdxW-1:0]       tag_idx_q [RD_LATENCY];

  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic            hi_vld, lo_vld;
  logic [IdxW-1:0] hi_idx, lo_idx;
  logic            rd_accept;

  // lo_* is the lowest-index requester; hi_* the lowest at or above rr_ptr, so the
  // round-robin winner is hi_* when present and otherwise wraps to lo_*.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = '0;
    lo_vld = 1'b0;
    lo_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld = 1'b1;
        lo_idx = IdxW'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (!reset) begin
      if (UseRr && hi_vld) begin
        win_vld = 1'b1;
        win_idx = hi_idx;
      end else if (lo_vld) begin
        win_vld = 1'b1;
        win_idx = lo_idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (win_vld) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!UseRr) begin
      rr_ptr_d = '0;
    end else if (win_vld) begin
      rr_ptr_d = (win_idx == IdxW'(N_CORES - 1)) ? '0 : win_idx + IdxW'(1);
    end
  end

  assign mem_wren    = win_vld & wren[win_idx];
  assign rd_accept   = win_vld & ~wren[win_idx];
  assign mem_address = win_vld ? addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_hold_q;
  assign mem_data    = win_vld ? wdata[win_idx*DATA_WIDTH +: DATA_WIDTH] : data_hold_q;
  assign rdata       = mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (win_vld) begin
        addr_hold_q <= mem_address;
        data_hold_q <= mem_data;
      end
    end
  end

  // Tag pipe tracks which core owns each in-flight read; writes occupy a slot as invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= rd_accept;
      tag_idx_q[0] <= win_idx;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (!reset && tag_vld_q[RD_LATENCY-1]) begin
      rvalid[tag_idx_q[RD_LATENCY-1]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Randomized bench: a round-robin (latency 2) and a fixed-priority (latency 1) arbiter,
// each with three cores and a RAM model, checked against a rule-level reference model.
module tb_shared_mem_arbiter;

  localparam int NC = 3;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam int NI = 2;

  typedef struct {
    int            inst;
    int            due;
    int            core;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic clk;
  logic reset;

  logic [NC-1:0]    req_s         [NI];
  logic [NC-1:0]    wren_s        [NI];
  logic [NC*AW-1:0] addr_s        [NI];
  logic [NC*DW-1:0] wdata_s       [NI];
  logic [NC-1:0]    gnt_s         [NI];
  logic [NC-1:0]    rvalid_s      [NI];
  logic [DW-1:0]    rdata_s       [NI];
  logic [AW-1:0]    mem_address_s [NI];
  logic [DW-1:0]    mem_data_s    [NI];
  logic             mem_wren_s    [NI];
  logic [DW-1:0]    mem_q_s       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    shared_mem_arbiter #(
      .N_CORES    (NC),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RD_LATENCY ((g == 0) ? 2 : 1),
      .ARB_MODE   (g)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req_s[g]),
      .wren        (wren_s[g]),
      .addr        (addr_s[g]),
      .wdata       (wdata_s[g]),
      .gnt         (gnt_s[g]),
      .rvalid      (rvalid_s[g]),
      .rdata       (rdata_s[g]),
      .mem_address (mem_address_s[g]),
      .mem_data    (mem_data_s[g]),
      .mem_wren    (mem_wren_s[g]),
      .mem_q       (mem_q_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state
  int            m_ptr       [NI];
  logic [AW-1:0] m_last_addr [NI];
  logic [DW-1:0] m_last_data [NI];
  logic          m_last_ok   [NI];
  logic [DW-1:0] ref_mem     [NI][16];
  rd_exp_t       exp_q[$];

  // RAM model state
  logic [DW-1:0] ram     [NI][16];
  logic [DW-1:0] rd_pipe [NI][2];

  // Core stimulus state: a request is held until granted
  logic          pend    [NI][NC];
  logic          p_wren  [NI][NC];
  logic [AW-1:0] p_addr  [NI][NC];
  logic [DW-1:0] p_wdata [NI][NC];

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input int g, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", tag, g, cyc, got, exp);
  endtask

  function automatic int exp_winner(input int g, input logic rst);
    int idx;
    if (rst) return -1;
    for (int k = 0; k < NC; k++) begin
      idx = (g == 1) ? k : (m_ptr[g] + k) % NC;
      if (pend[g][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic run_cycle(input logic rst);
    int            win;
    int            found;
    logic [NC-1:0] exp_gnt;
    logic [NC-1:0] exp_rv;
    logic [DW-1:0] exp_rd;
    logic [AW-1:0] s_addr [NI];
    logic [DW-1:0] s_data [NI];
    logic          s_wren [NI];
    logic [NC-1:0] s_gnt  [NI];

    @(negedge clk);
    reset = rst;
    for (int g = 0; g < NI; g++) begin
      for (int i = 0; i < NC; i++) begin
        if (!pend[g][i] && $urandom_range(0, 99) < 55) begin
          pend[g][i]    = 1'b1;
          p_wren[g][i]  = ($urandom_range(0, 2) == 0);
          p_addr[g][i]  = AW'($urandom_range(0, 15));
          p_wdata[g][i] = DW'($urandom);
        end
        req_s[g][i] = pend[g][i];
        if (pend[g][i]) begin
          wren_s[g][i]            = p_wren[g][i];
          addr_s[g][i*AW +: AW]   = p_addr[g][i];
          wdata_s[g][i*DW +: DW]  = p_wdata[g][i];
        end else begin
          // Idle cores present junk that must never leak through the mux
          wren_s[g][i]            = 1'($urandom);
          addr_s[g][i*AW +: AW]   = AW'($urandom);
          wdata_s[g][i*DW +: DW]  = DW'($urandom);
        end
      end
    end
    #1;

    for (int g = 0; g < NI; g++) begin
      win     = exp_winner(g, rst);
      exp_gnt = '0;
      if (win >= 0) exp_gnt[win] = 1'b1;
      check_eq("gnt", g, 32'(gnt_s[g]), 32'(exp_gnt));
      check_eq("mem_wren", g, 32'(mem_wren_s[g]), 32'((win >= 0) && p_wren[g][win]));
      if (win >= 0) begin
        check_eq("mem_address", g, 32'(mem_address_s[g]), 32'(p_addr[g][win]));
        if (p_wren[g][win]) check_eq("mem_data", g, 32'(mem_data_s[g]), 32'(p_wdata[g][win]));
      end else if (m_last_ok[g]) begin
        check_eq("hold_address", g, 32'(mem_address_s[g]), 32'(m_last_addr[g]));
        check_eq("hold_data", g, 32'(mem_data_s[g]), 32'(m_last_data[g]));
      end

      exp_rv = '0;
      exp_rd = '0;
      found  = 0;
      foreach (exp_q[j]) begin
        if (exp_q[j].inst == g && exp_q[j].due == cyc) begin
          exp_rv[exp_q[j].core] = 1'b1;
          exp_rd                = exp_q[j].data;
          found                 = 1;
        end
      end
      if (rst) exp_rv = '0;
      check_eq("rvalid", g, 32'(rvalid_s[g]), 32'(exp_rv));
      if (found == 1 && !rst) check_eq("rdata", g, 32'(rdata_s[g]), 32'(exp_rd));

      for (int j = exp_q.size() - 1; j >= 0; j--) begin
        if (exp_q[j].inst == g && (rst || exp_q[j].due <= cyc)) exp_q.delete(j);
      end

      if (rst) begin
        m_ptr[g]       = 0;
        m_last_addr[g] = '0;
        m_last_data[g] = '0;
        m_last_ok[g]   = 1'b1;
      end else if (win >= 0) begin
        m_last_addr[g] = p_addr[g][win];
        m_last_data[g] = p_wdata[g][win];
        if (g == 0) m_ptr[g] = (win + 1) % NC;
        if (p_wren[g][win]) begin
          ref_mem[g][p_addr[g][win][3:0]] = p_wdata[g][win];
        end else begin
          exp_q.push_back('{inst: g, due: cyc + lat_of(g), core: win,
                            data: ref_mem[g][p_addr[g][win][3:0]]});
        end
      end

      s_addr[g] = mem_address_s[g];
      s_data[g] = mem_data_s[g];
      s_wren[g] = mem_wren_s[g];
      s_gnt[g]  = gnt_s[g];
    end

    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      for (int s = lat_of(g) - 1; s >= 1; s--) rd_pipe[g][s] = rd_pipe[g][s-1];
      rd_pipe[g][0] = ram[g][s_addr[g][3:0]];
      if (s_wren[g]) ram[g][s_addr[g][3:0]] = s_data[g];
      mem_q_s[g] = rd_pipe[g][lat_of(g) - 1];
      for (int i = 0; i < NC; i++) begin
        if (!rst && s_gnt[g][i] && pend[g][i]) pend[g][i] = 1'b0;
      end
    end
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      req_s[g]       = '0;
      wren_s[g]      = '0;
      addr_s[g]      = '0;
      wdata_s[g]     = '0;
      mem_q_s[g]     = '0;
      m_ptr[g]       = 0;
      m_last_addr[g] = '0;
      m_last_data[g] = '0;
      m_last_ok[g]   = 1'b0;
      for (int s = 0; s < 2; s++) rd_pipe[g][s] = '0;
      for (int a = 0; a < 16; a++) begin
        ram[g][a]     = '0;
        ref_mem[g][a] = '0;
      end
      for (int i = 0; i < NC; i++) begin
        pend[g][i]    = 1'b0;
        p_wren[g][i]  = 1'b0;
        p_addr[g][i]  = '0;
        p_wdata[g][i] = '0;
      end
    end

    for (int n = 0; n < 3; n++) run_cycle(1'b1);
    for (int n = 0; n < 3000; n++) begin
      run_cycle((n == 300) || (n == 301 + 2) || ($urandom_range(0, 99) == 0));
    end
    run_cycle(1'b0);
    run_cycle(1'b0);
    run_cycle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
